ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_host_tx                                                     |
// | Purpose  : PS/2 host-to-device command transmitter (inhibit, frame, ACK).  |
// |            Optional abort timer enabled by defining PS2_TX_TIMEOUT_EN.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [9:0]         r_frame, w_frame;
  logic [c_INH_W-1:0] r_cnt, w_cnt;
  logic [3:0]         r_idx, w_idx;
  logic               r_clk_oe, w_clk_oe;
  logic               r_data_oe, w_data_oe;
  logic               r_ack_ok, w_ack_ok;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               w_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TMO_W-1:0] r_tmo, w_tmo;
`endif

  assign w_fall = ~r_clk_s1 & r_clk_s2;

  always_comb begin
    w_state   = r_state;
    w_frame   = r_frame;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_clk_oe  = r_clk_oe;
    w_data_oe = r_data_oe;
    w_ack_ok  = r_ack_ok;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        if (tx_vld) begin
          w_frame  = {1'b1, ~^tx_data, tx_data};
          w_clk_oe = 1'b1;
          w_cnt    = '0;
          w_state  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == c_INH_LAST) begin
          w_clk_oe  = 1'b0;
          w_data_oe = 1'b1;
          w_idx     = '0;
          w_state   = ST_SEND;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_SEND: begin
        if (w_fall) begin
          w_data_oe = ~r_frame[r_idx];
          w_idx     = r_idx + 4'd1;
          // Stop bit is a released line, so the block already lets go of data here
          if (r_idx == 4'd9) begin
            w_data_oe = 1'b0;
            w_state   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (w_fall) begin
          w_ack_ok = ~r_dat_s2;
          w_state  = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_done  = r_ack_ok;
          w_err   = ~r_ack_ok;
          w_idx   = '0;
          w_state = ST_IDLE;
        end
      end
      default: begin
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        w_state   = ST_IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    w_tmo = '0;
    if (r_state == ST_SEND || r_state == ST_ACK) begin
      if (r_tmo == c_TMO_LAST) begin
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b1;
        w_idx     = '0;
        w_state   = ST_IDLE;
      end else begin
        w_tmo = r_tmo + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_frame   <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_clk_s1  <= ps2_clk_in;
      r_clk_s2  <= r_clk_s1;
      r_dat_s1  <= ps2_data_in;
      r_dat_s2  <= r_dat_s1;
      r_frame   <= w_frame;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_clk_oe  <= w_clk_oe;
      r_data_oe <= w_data_oe;
      r_ack_ok  <= w_ack_ok;
      r_done    <= w_done;
      r_err     <= w_err;
`ifdef PS2_TX_TIMEOUT_EN
      r_tmo     <= w_tmo;
`endif
    end
  end

  assign tx_rdy      = (r_state == ST_IDLE);
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire
